// File: rtl/aes_ctr_block_gen_if.sv
// Bundle of the control, job parameters and encryptor-facing signals for aes_ctr_block_gen.
// The slave modport is the generator side; the master modport is the job issuer and encryptor side.
interface aes_ctr_block_gen_if #(
  parameter int CNT_W = 32
);
  logic             start;
  logic [95:0]      nonce;
  logic [127:0]     key_in;
  logic [31:0]      init_ctr;
  logic [CNT_W-1:0] num_blocks;
  logic             pause;
  logic [127:0]     blk_out;
  logic [127:0]     key_out;
  logic             issue;
  logic             ks_valid;
  logic             busy;
  logic             done;

  modport slave (
    input  start, nonce, key_in, init_ctr, num_blocks, pause,
    output blk_out, key_out, issue, ks_valid, busy, done
  );

  modport master (
    output start, nonce, key_in, init_ctr, num_blocks, pause,
    input  blk_out, key_out, issue, ks_valid, busy, done
  );
endinterface

// File: rtl/aes_ctr_block_gen.sv
// CTR-mode counter block generator feeding a pipelined AES core, with a delay line
// matched to the core latency that marks which core output cycles carry keystream.
module aes_ctr_block_gen #(
  parameter int LATENCY = 12,
  parameter int CNT_W   = 32
) (
  input logic                clk,
  input logic                rst_n,
  aes_ctr_block_gen_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t             r_state;
  logic [95:0]        r_nonce;
  logic [127:0]       r_key;
  logic [127:0]       r_blk;
  logic [31:0]        r_ctr;
  logic [CNT_W-1:0]   r_rem;
  logic               r_issue;
  logic               r_busy;
  logic               r_done;
  logic [LATENCY-1:0] r_dly;
  logic [LATENCY-1:0] w_dly_next;

  // Looking at the next delay-line value lets done rise on the same edge the last ks_valid falls.
  assign w_dly_next = (r_dly << 1) | LATENCY'(r_issue);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_nonce <= '0;
      r_key   <= '0;
      r_blk   <= '0;
      r_ctr   <= '0;
      r_rem   <= '0;
      r_issue <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dly   <= '0;
    end else begin
      r_dly  <= w_dly_next;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_issue <= 1'b0;
          if (bus.start) begin
            r_nonce <= bus.nonce;
            r_key   <= bus.key_in;
            r_ctr   <= bus.init_ctr;
            r_rem   <= bus.num_blocks;
            if (bus.num_blocks != '0) begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (!bus.pause) begin
            r_blk   <= {r_nonce, r_ctr};
            r_issue <= 1'b1;
            r_ctr   <= r_ctr + 32'd1;
            r_rem   <= r_rem - CNT_W'(1);
            if (r_rem == CNT_W'(1)) begin
              r_state <= S_DRAIN;
            end
          end else begin
            r_issue <= 1'b0;
          end
        end
        S_DRAIN: begin
          r_issue <= 1'b0;
          if (w_dly_next == '0) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_issue <= 1'b0;
        end
      endcase
    end
  end

  assign bus.blk_out  = r_blk;
  assign bus.key_out  = r_key;
  assign bus.issue    = r_issue;
  assign bus.ks_valid = r_dly[LATENCY-1];
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
endmodule

// File: tb/tb_aes_ctr_block_gen.sv
// Self-checking bench for aes_ctr_block_gen: table of jobs plus hand-written reset and
// back-to-back sequences, with a scoreboard for issued blocks and ks_valid timing.
module tb_aes_ctr_block_gen;
  localparam int LAT = 12;

  logic clk;
  logic rst_n;

  aes_ctr_block_gen_if #(.CNT_W(32)) bus ();

  aes_ctr_block_gen #(.LATENCY(LAT), .CNT_W(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [95:0] nonce;
    logic [31:0] init;
    int          n;
    int          pa;        // first loop index with pause high (-1: none)
    int          pl;        // pause length in cycles
    int          ra;        // loop index for an ignored start during RUN (-1: none)
    logic [31:0] exp_last;  // counter field of the final issued block
    int          exp_done;  // edge index (E0 = start edge) after which done is high
  } vec_t;

  int            total = 0;
  int            bad   = 0;
  int            cyc   = 0;
  logic [127:0]  exp_q[$];
  int            ks_q[$];
  logic [127:0]  exp_key = '0;
  logic [127:0]  last_blk = '0;
  vec_t          vecs[7];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: each issue pops one expected block and schedules a ks_valid LAT cycles later.
  always @(posedge clk) begin
    logic exp_ks;
    #1;
    cyc++;
    if (!rst_n) begin
      ks_q.delete();
    end else begin
      exp_ks = (ks_q.size() != 0) && (ks_q[0] == cyc);
      if (exp_ks) void'(ks_q.pop_front());
      check("ks_valid", 128'(bus.ks_valid), 128'(exp_ks));
      if (bus.issue) begin
        ks_q.push_back(cyc + LAT);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL issue_extra actual=%0h required=none", bus.blk_out);
        end else begin
          check("blk_out", bus.blk_out, exp_q.pop_front());
          check("key_out", bus.key_out, exp_key);
        end
        last_blk = bus.blk_out;
      end else begin
        check("blk_hold", bus.blk_out, last_blk);
      end
    end
  end

  task automatic run_job(input vec_t v, input logic [127:0] key, input bit b2b);
    int done_edge;
    for (int i = 0; i < v.n; i++) exp_q.push_back({v.nonce, v.init + 32'(i)});
    @(negedge clk);
    exp_key        = key;
    bus.start      = 1'b1;
    bus.nonce      = v.nonce;
    bus.key_in     = key;
    bus.init_ctr   = v.init;
    bus.num_blocks = 32'(v.n);
    @(posedge clk);
    #1;
    check("busy_after_start", 128'(bus.busy), 128'(v.n != 0));
    done_edge = bus.done ? 0 : -1;
    for (int k = 0; k < 300 && done_edge < 0; k++) begin
      @(negedge clk);
      bus.start = (k == v.ra);
      if (k == v.ra) begin
        bus.key_in     = ~key;
        bus.nonce      = ~v.nonce;
        bus.init_ctr   = 32'h0;
        bus.num_blocks = 32'd7;
      end
      bus.pause = (v.pa >= 0) && (k >= v.pa) && (k < v.pa + v.pl);
      @(posedge clk);
      #1;
      if (bus.done) done_edge = k + 1;
    end
    bus.start = 1'b0;
    bus.pause = 1'b0;
    check("done_edge", 128'(done_edge), 128'(v.exp_done));
    check("blocks_left", 128'(exp_q.size()), 128'(0));
    check("key_held", bus.key_out, key);
    if (v.n != 0) check("last_ctr", 128'(last_blk[31:0]), 128'(v.exp_last));
    if (!b2b) begin
      @(posedge clk);
      #1;
      check("done_pulse_len", 128'(bus.done), 128'(0));
      check("busy_after_done", 128'(bus.busy), 128'(0));
    end
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check("idle_done", 128'(bus.done), 128'(0));
      check("idle_busy", 128'(bus.busy), 128'(0));
      check("idle_issue", 128'(bus.issue), 128'(0));
    end
  endtask

  task automatic check_all_zero();
    check("rst_blk_out", bus.blk_out, 128'(0));
    check("rst_key_out", bus.key_out, 128'(0));
    check("rst_issue", 128'(bus.issue), 128'(0));
    check("rst_ks_valid", 128'(bus.ks_valid), 128'(0));
    check("rst_busy", 128'(bus.busy), 128'(0));
    check("rst_done", 128'(bus.done), 128'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vr;
    vecs[0] = '{{24{4'hA}} ^ {12{8'h0F}} ^ {12{8'h0F}}, 32'd5, 4, -1, 0, -1, 32'd8, 17};
    vecs[1] = '{96'h0123_4567_89AB_CDEF_0011_2233, 32'hFFFF_FFFE, 4, -1, 0, -1, 32'h1, 17};
    vecs[2] = '{96'hCAFE_F00D_1234_5678_9ABC_DEF0, 32'h10, 3, 1, 2, -1, 32'h12, 18};
    vecs[3] = '{96'h1, 32'h55, 0, -1, 0, -1, 32'h0, 0};
    vecs[4] = '{96'hFEED_BEEF_0000_1111_2222_3333, 32'd100, 6, -1, 0, 2, 32'd105, 19};
    vecs[5] = '{96'h0, 32'hDEAD, 1, -1, 0, -1, 32'hDEAD, 14};
    vecs[6] = '{96'h7777_0000_8888_0000_9999_0000, 32'h7FFF_FFF0, 20, 5, 3, -1, 32'h8000_0003, 36};

    bus.start = 1'b0; bus.pause = 1'b0; bus.nonce = '0; bus.key_in = '0;
    bus.init_ctr = '0; bus.num_blocks = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2 check_all_zero();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    idle_check(20);

    for (int i = 0; i < 7; i++) begin
      run_job(vecs[i], {32'h0BAD_C0DE, 32'(i), 32'h1357_9BDF, 32'h2468_ACE0 ^ 32'(i)}, 1'b0);
    end

    // New start in the done cycle of the previous job.
    run_job(vecs[5], 128'h1111_2222_3333_4444_5555_6666_7777_8888, 1'b1);
    run_job(vecs[0], 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000, 1'b0);

    // Reset while five blocks are in flight in the encryptor.
    for (int i = 0; i < 5; i++) exp_q.push_back({96'hABCD_0000_0000_0000_0000_0001, 32'h40 + 32'(i)});
    @(negedge clk);
    exp_key        = 128'h5A5A;
    bus.start      = 1'b1;
    bus.nonce      = 96'hABCD_0000_0000_0000_0000_0001;
    bus.key_in     = 128'h5A5A;
    bus.init_ctr   = 32'h40;
    bus.num_blocks = 32'd5;
    @(negedge clk) bus.start = 1'b0;
    repeat (7) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_all_zero();
    check("mid_rst_blocks_issued", 128'(exp_q.size()), 128'(0));
    exp_q.delete();
    ks_q.delete();
    last_blk = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    idle_check(20);
    vr = '{96'h0F0F_0F0F_0F0F_0F0F_0F0F_0F0F, 32'h1234, 3, -1, 0, -1, 32'h1236, 16};
    run_job(vr, 128'hC3C3_C3C3, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
